// File: rtl/l2_node_rx_port.sv
// rtl/l2_node_rx_port.sv - receive port of one end node in the L2 switch simulator
//
// Accepts 3-byte frames {DST,SRC} / {x,PAYLOAD} / checksum (B0^B1) from a
// switch egress port, validates checksum and destination, and presents the
// delivered frame to the node's display logic with statistics counters.
//
// Ports:
//   FPGA_CLK, FPGA_RST_BTN          clock, async active-low reset
//   in_valid/in_sof/in_data/in_ready  byte-serial ingress handshake
//   out_valid/out_ready              delivered-frame handshake
//   out_dst/out_src/out_payload      delivered frame fields
//   flag_clr/rx_flag                 sticky receive indicator and its clear
//   rx_frame_cnt/crc_err_cnt/sync_err_cnt  saturating 8-bit statistics

module l2_node_rx_port #(
  parameter logic [3:0] NODE_ADDR  = 4'hA,
  parameter logic [3:0] BCAST_ADDR = 4'hF
) (
  input  logic       FPGA_CLK,
  input  logic       FPGA_RST_BTN,
  input  logic       in_valid,
  input  logic       in_sof,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_dst,
  output logic [3:0] out_src,
  output logic [3:0] out_payload,
  input  logic       flag_clr,
  output logic       rx_flag,
  output logic [7:0] rx_frame_cnt,
  output logic [7:0] crc_err_cnt,
  output logic [7:0] sync_err_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_PAY, S_CHK, S_OUT} state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_hdr;
  logic [7:0] r_pay;
  logic [3:0] r_out_dst;
  logic [3:0] r_out_src;
  logic [3:0] r_out_payload;
  logic       r_rx_flag;
  logic [7:0] r_rx_frame_cnt;
  logic [7:0] r_crc_err_cnt;
  logic [7:0] r_sync_err_cnt;

  logic w_xfer;
  logic w_latch_hdr;
  logic w_latch_pay;
  logic w_deliver;
  logic w_sync_err;
  logic w_crc_err;
  logic w_dst_match;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign in_ready    = (r_state != S_OUT);
  assign out_valid   = (r_state == S_OUT);
  assign w_xfer      = in_valid && in_ready;
  assign w_dst_match = (r_hdr[7:4] == NODE_ADDR) || (r_hdr[7:4] == BCAST_ADDR);

  always_comb begin
    w_state_nxt = r_state;
    w_latch_hdr = 1'b0;
    w_latch_pay = 1'b0;
    w_deliver   = 1'b0;
    w_sync_err  = 1'b0;
    w_crc_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          if (in_sof) begin
            w_latch_hdr = 1'b1;
            w_state_nxt = S_PAY;
          end else begin
            w_sync_err = 1'b1;
          end
        end
      end
      S_PAY: begin
        if (w_xfer) begin
          if (in_sof) begin
            // Header arriving mid-frame restarts the frame with this byte.
            w_sync_err  = 1'b1;
            w_latch_hdr = 1'b1;
          end else begin
            w_latch_pay = 1'b1;
            w_state_nxt = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (w_xfer) begin
          if (in_sof) begin
            w_sync_err  = 1'b1;
            w_latch_hdr = 1'b1;
            w_state_nxt = S_PAY;
          end else if (in_data != (r_hdr ^ r_pay)) begin
            w_crc_err   = 1'b1;
            w_state_nxt = S_IDLE;
          end else if (w_dst_match) begin
            w_deliver   = 1'b1;
            w_state_nxt = S_OUT;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_OUT: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge FPGA_CLK or negedge FPGA_RST_BTN) begin
    if (!FPGA_RST_BTN) begin
      r_state        <= S_IDLE;
      r_hdr          <= 8'h00;
      r_pay          <= 8'h00;
      r_out_dst      <= 4'h0;
      r_out_src      <= 4'h0;
      r_out_payload  <= 4'h0;
      r_rx_flag      <= 1'b0;
      r_rx_frame_cnt <= 8'h00;
      r_crc_err_cnt  <= 8'h00;
      r_sync_err_cnt <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch_hdr) r_hdr <= in_data;
      if (w_latch_pay) r_pay <= in_data;
      if (w_deliver) begin
        r_out_dst      <= r_hdr[7:4];
        r_out_src      <= r_hdr[3:0];
        r_out_payload  <= r_pay[3:0];
        r_rx_frame_cnt <= sat_inc(r_rx_frame_cnt);
      end
      // A delivery on the same edge as a clear leaves the flag set.
      if (w_deliver)     r_rx_flag <= 1'b1;
      else if (flag_clr) r_rx_flag <= 1'b0;
      if (w_crc_err)  r_crc_err_cnt  <= sat_inc(r_crc_err_cnt);
      if (w_sync_err) r_sync_err_cnt <= sat_inc(r_sync_err_cnt);
    end
  end

  assign out_dst      = r_out_dst;
  assign out_src      = r_out_src;
  assign out_payload  = r_out_payload;
  assign rx_flag      = r_rx_flag;
  assign rx_frame_cnt = r_rx_frame_cnt;
  assign crc_err_cnt  = r_crc_err_cnt;
  assign sync_err_cnt = r_sync_err_cnt;

endmodule

// File: tb/tb_l2_node_rx_port.sv
// tb/tb_l2_node_rx_port.sv - directed self-checking bench for l2_node_rx_port

module tb_l2_node_rx_port;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_sof;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_dst;
  logic [3:0] out_src;
  logic [3:0] out_payload;
  logic       flag_clr;
  logic       rx_flag;
  logic [7:0] rx_frame_cnt;
  logic [7:0] crc_err_cnt;
  logic [7:0] sync_err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  l2_node_rx_port #(.NODE_ADDR(4'hC), .BCAST_ADDR(4'hF)) dut (
    .FPGA_CLK     (clk),
    .FPGA_RST_BTN (rst_n),
    .in_valid     (in_valid),
    .in_sof       (in_sof),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_dst      (out_dst),
    .out_src      (out_src),
    .out_payload  (out_payload),
    .flag_clr     (flag_clr),
    .rx_flag      (rx_flag),
    .rx_frame_cnt (rx_frame_cnt),
    .crc_err_cnt  (crc_err_cnt),
    .sync_err_cnt (sync_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    flag_clr  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Presents one byte and returns #1 after the edge that accepted it.
  task automatic send_byte(input logic [7:0] d, input logic sof);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0, 1'b1);
    send_byte(b1, 1'b0);
    send_byte(b2, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    flag_clr  = 1'b0;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_flag", 32'(rx_flag), 32'd0);
    chk("rst_counts", {8'h0, rx_frame_cnt, crc_err_cnt, sync_err_cnt}, 32'd0);
    chk("rst_fields", {20'h0, out_dst, out_src, out_payload}, 32'd0);

    // Unicast delivery to this node.
    do_reset();
    send_frame(8'hCA, 8'h05, 8'hCF);
    chk("uc_valid", 32'(out_valid), 32'd1);
    chk("uc_fields", {20'h0, out_dst, out_src, out_payload}, 32'h00000CA5);
    chk("uc_flag", 32'(rx_flag), 32'd1);
    chk("uc_counts", {8'h0, rx_frame_cnt, crc_err_cnt, sync_err_cnt}, 32'h00010000);
    chk("uc_in_ready_out", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("uc_valid_drop", 32'(out_valid), 32'd0);
    chk("uc_in_ready_back", 32'(in_ready), 32'd1);

    // Foreign destination dropped, broadcast delivered.
    do_reset();
    send_frame(8'hDB, 8'h05, 8'hDE);
    chk("drop_valid", 32'(out_valid), 32'd0);
    chk("drop_counts", {8'h0, rx_frame_cnt, crc_err_cnt, sync_err_cnt}, 32'd0);
    chk("drop_flag", 32'(rx_flag), 32'd0);
    send_frame(8'hF1, 8'h05, 8'hF4);
    chk("bc_valid", 32'(out_valid), 32'd1);
    chk("bc_fields", {20'h0, out_dst, out_src, out_payload}, 32'h00000F15);
    chk("bc_cnt", 32'(rx_frame_cnt), 32'd1);

    // Checksum error, stray byte, and header abort.
    do_reset();
    send_frame(8'hCA, 8'h05, 8'h00);
    chk("crc_cnt", 32'(crc_err_cnt), 32'd1);
    chk("crc_valid", 32'(out_valid), 32'd0);
    send_byte(8'h07, 1'b0);
    chk("sync_idle", 32'(sync_err_cnt), 32'd1);
    send_byte(8'hCA, 1'b1);
    send_byte(8'hCA, 1'b1);
    chk("sync_abort", 32'(sync_err_cnt), 32'd2);
    send_byte(8'h05, 1'b0);
    send_byte(8'hCF, 1'b0);
    chk("abort_deliver", {31'h0, out_valid}, 32'd1);
    chk("abort_fields", {20'h0, out_dst, out_src, out_payload}, 32'h00000CA5);
    chk("abort_counts", {8'h0, rx_frame_cnt, crc_err_cnt, sync_err_cnt}, 32'h00010102);

    // Backpressure on the delivered frame stalls upstream.
    do_reset();
    out_ready = 1'b0;
    send_frame(8'hCA, 8'h05, 8'hCF);
    in_valid = 1'b1;
    in_sof   = 1'b1;
    in_data  = 8'hC3;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_fields", {20'h0, out_dst, out_src, out_payload}, 32'h00000CA5);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    chk("bp_sync_clean", 32'(sync_err_cnt), 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_hs_valid", 32'(out_valid), 32'd0);
    chk("bp_hs_in_ready", 32'(in_ready), 32'd1);
    chk("bp_hs_keep", {20'h0, out_dst, out_src, out_payload}, 32'h00000CA5);
    send_byte(8'hC3, 1'b1);
    send_byte(8'h07, 1'b0);
    send_byte(8'hC4, 1'b0);
    chk("bp_next_valid", 32'(out_valid), 32'd1);
    chk("bp_next_fields", {20'h0, out_dst, out_src, out_payload}, 32'h00000C37);
    chk("bp_next_cnt", 32'(rx_frame_cnt), 32'd2);

    // flag_clr coinciding with delivery, then alone.
    send_byte(8'hCA, 1'b1);
    send_byte(8'h05, 1'b0);
    flag_clr = 1'b1;
    send_byte(8'hCF, 1'b0);
    chk("flag_set_wins", 32'(rx_flag), 32'd1);
    @(posedge clk);
    #1;
    flag_clr = 1'b0;
    chk("flag_cleared", 32'(rx_flag), 32'd0);
    chk("flag_cnt", 32'(rx_frame_cnt), 32'd3);

    // Asynchronous reset mid-frame.
    send_byte(8'hCA, 1'b1);
    send_byte(8'h05, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("amid_counts", {8'h0, rx_frame_cnt, crc_err_cnt, sync_err_cnt}, 32'd0);
    chk("amid_fields", {20'h0, out_dst, out_src, out_payload}, 32'd0);
    chk("amid_flag_valid", {30'h0, rx_flag, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_byte(8'hCF, 1'b0);
    chk("post_rst_stray", {16'h0, crc_err_cnt, sync_err_cnt}, 32'h00000001);
    send_frame(8'hCA, 8'h05, 8'hCF);
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_cnt", 32'(rx_frame_cnt), 32'd1);

    // Error counter saturation.
    for (int i = 0; i < 300; i++) begin
      send_frame(8'hCA, 8'h05, 8'h00);
    end
    chk("crc_sat", 32'(crc_err_cnt), 32'hFF);
    chk("sat_others", {16'h0, rx_frame_cnt, sync_err_cnt}, 32'h00000101);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/l2_node_rx_port.md
Name: l2_node_rx_port

Overview:
- Host-side receive port of one simulated end node (A..D) in the L2 switch simulator.
- Accepts byte-serial frames from a switch egress port through a valid/ready handshake.
- Checks each frame's checksum and destination against the node address, and delivers matching frames (source, destination, payload) to the node's LED/LCD logic.
- Keeps a sticky "received" flag and saturating statistics counters.
- It is the receiving end of the frame format the transmit queue produces from DST/SRC switches plus the keypad payload.

Parameters:
- NODE_ADDR, 4'hA, this node's 4-bit address.
- BCAST_ADDR, 4'hF, broadcast destination, accepted by every node.

Ports:
- FPGA_CLK  in  1  system clock, all logic on rising edge.
- FPGA_RST_BTN  in  1  asynchronous active-low reset.
- in_valid  in  1  egress byte valid.
- in_sof  in  1  marks the current byte as the first byte (header) of a frame; qualified by in_valid.
- in_data  in  8  egress byte.
- in_ready  out  1  port can accept a byte this cycle.
- out_valid  out  1  delivered frame available.
- out_ready  in  1  consumer accepts the delivered frame.
- out_dst  out  4  destination of the delivered frame.
- out_src  out  4  source of the delivered frame.
- out_payload  out  4  payload nibble of the delivered frame.
- flag_clr  in  1  single-cycle clear of rx_flag.
- rx_flag  out  1  sticky: at least one frame delivered since reset or clear.
- rx_frame_cnt  out  8  delivered frames, saturates at 255.
- crc_err_cnt  out  8  checksum failures, saturates at 255.
- sync_err_cnt  out  8  framing errors, saturates at 255.

Behaviour:
- Frame format, 3 bytes:
  - B0 = {DST[7:4], SRC[3:0]}, with in_sof=1.
  - B1 = {4'h0, PAYLOAD[3:0]}; upper nibble is ignored but included in the checksum.
  - B2 = B0 XOR B1.
- A byte transfers on a rising edge when in_valid && in_ready.
- Reset (asynchronous, any time including mid-frame):
  - state = IDLE.
  - All outputs and counters = 0: out_valid, out_dst, out_src, out_payload, rx_flag and all counters.
  - in_ready = 1 from the first edge after release; it is combinational on state.
- FSM states: IDLE, PAY, CHK, OUT.
  - in_ready = 1 in IDLE, PAY and CHK; 0 in OUT.
- IDLE:
  - Byte with in_sof=1: latch dst/src, go to PAY.
  - Byte with in_sof=0: discard, sync_err_cnt+1, stay in IDLE.
- PAY:
  - Byte with in_sof=0: latch payload byte, go to CHK.
  - Byte with in_sof=1: abort the current frame, sync_err_cnt+1, treat the byte as a new B0, stay in PAY.
- CHK:
  - Byte with in_sof=1: same abort rule as PAY, go to PAY.
  - Byte with in_sof=0, checksum mismatch: crc_err_cnt+1, go to IDLE; no other effect.
  - Checksum OK, dst not NODE_ADDR and not BCAST_ADDR: silently drop, go to IDLE; no counter changes.
  - Checksum OK, dst matches: load out_dst/out_src/out_payload, out_valid=1, rx_frame_cnt+1, rx_flag=1, go to OUT.
- Latency: out_valid is high the cycle after the edge that accepts B2.
- OUT:
  - out_valid and the out_* fields stay stable until out_valid && out_ready on an edge.
  - After that edge: out_valid=0, state IDLE, in_ready=1 in the next cycle (one bubble cycle).
  - out_* fields keep the last delivered values after the handshake.
- in_valid idle cycles inside a frame are allowed, with no timeout; the FSM holds its state.
- rx_flag:
  - flag_clr=1 clears it on the next edge.
  - If a delivery and flag_clr occur on the same edge, set wins (rx_flag=1).
- Counters are 8-bit and hold at 8'hFF; no wrap.
- No frame is ever partially delivered. An abort or reset mid-frame discards all latched bytes.

Test Plan:
- NODE_ADDR=C; send CA,05,CF with out_ready=1 -> out_valid pulses one cycle after CF is accepted, out_dst=C, out_src=A, out_payload=5, rx_flag=1, rx_frame_cnt=1, no error counts.
- NODE_ADDR=C; send DB,05,DE then F1,05,F4 -> first frame dropped (no out_valid, counters unchanged); broadcast delivered with out_src=1, rx_frame_cnt=1.
- Send CA,05,00 -> crc_err_cnt=1, no out_valid; then byte 07 with in_sof=0 while IDLE -> sync_err_cnt=1; then CA(sof),CA(sof),05,CF -> sync_err_cnt=2, frame delivered.
- Deliver a frame with out_ready=0 for 5 cycles -> out_valid and fields stable, in_ready=0 and the upstream next frame stalls; raise out_ready -> handshake, in_ready=1 the following cycle, next frame received intact.
- Assert flag_clr on the same edge as a delivery -> rx_flag stays 1; flag_clr alone the next cycle -> rx_flag=0.
- Pull FPGA_RST_BTN low after accepting CA,05 -> all outputs 0 immediately; after release, send CA,05,CF -> delivered normally, rx_frame_cnt=1. Drive 300 bad frames -> crc_err_cnt holds at FF.
